hazard_unit: RTL

Central stall/flush/forward controller for the five-stage RV64I-Zba pipeline. It reads the register addresses and control fields leaving the Decode→Execute register and the later stages, and drives back the hold enables, synchronous clears and operand-forward selects that control those registers. It also models multi-cycle data-memory access with a small FSM and keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_unit_forward_sel.sv | 19 +
 rtl/hazard_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and memory-FSM state type for the pipeline hazard controller.
package hazard_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {RUN, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Operand forward select for one Execute source register; Memory beats Writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs_e)
      fwd = FWD_M;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs_e)
      fwd = FWD_W;
  end
endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller with multi-cycle memory FSM and saturating perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic             RegWrite_M,
  input  logic             MemAccess_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_W,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  // WAIT burns DMEM_LAT-3 extra cycles on top of the RUN and last WAIT cycle.
  localparam logic [3:0] CNT_INIT = (DMEM_LAT > 2) ? 4'(DMEM_LAT - 3) : 4'd0;

  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign rs_e = {Rs2_E, Rs1_E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    forward_sel u_fwd (
      .rs_e        (rs_e[i]),
      .rd_m        (Rd_M),
      .reg_write_m (RegWrite_M),
      .rd_w        (Rd_W),
      .reg_write_w (RegWrite_W),
      .fwd         (fwd[i])
    );
  end

  assign ForwardA_E = rst_n ? fwd[0] : FWD_RF;
  assign ForwardB_E = rst_n ? fwd[1] : FWD_RF;

  mem_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mstall;
  logic       lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DONE masks MemAccess_M: the finished access is still sitting in Memory.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mstall    = 1'b0;
    case (state)
      RUN: begin
        if (MemAccess_M && DMEM_LAT > 1) begin
          mstall = 1'b1;
          if (DMEM_LAT == 2) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        mstall = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign lu = (ResultSrc_E == RES_MEM) && (Rd_E != 5'd0) &&
              ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (rst_n) begin
      if (mstall) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
        Flush_W = 1'b1;
      end else if (PCSrc_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (lu) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (Stall_F && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
      if (Flush_D && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
    end
  end
endmodule
